// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: drives all 16 input vectors of an external 4-input
// combinational function, one per cycle. It captures each response into a
// truth table and compares the table against a golden table that is
// registered when the sweep starts.
// Optional build macro: KMAP_SWEEP_FIRSTERR_EN adds first-mismatch logging.
// When the macro is undefined, first_err_* are tied to 0.
// The keyword 'expect' cannot name a port, so every port except clk and
// rst_n carries an _i or _o suffix.
module kmap_sweep_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [15:0] expect_i,
   input  logic        kmap_out_i,
   output logic        kmap_a_o,
   output logic        kmap_b_o,
   output logic        kmap_c_o,
   output logic        kmap_d_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] truth_o,
   output logic        pass_o,
   output logic [4:0]  err_cnt_o,
   output logic [3:0]  first_err_idx_o,
   output logic        first_err_vld_o
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_e;

   state_e      state_q;
   logic [3:0]  idx_q;
   logic [15:0] expect_q;
   logic [15:0] truth_q;
   logic [4:0]  err_cnt_q;
   logic        busy_q;
   logic        done_q;
   logic        pass_q;

   logic [15:0] truth_d;
   logic        mism;

   // Truth table including this cycle's capture, and the mismatch for this capture.
   always_comb begin
      truth_d        = truth_q;
      truth_d[idx_q] = kmap_out_i;
      mism           = kmap_out_i ^ expect_q[idx_q];
   end

   // Sweep FSM with registered status and result outputs. idx is 0 outside
   // SWEEP, so it can drive the stimulus pins directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= 4'd0;
         expect_q  <= 16'd0;
         truth_q   <= 16'd0;
         err_cnt_q <= 5'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q   <= S_SWEEP;
                  busy_q    <= 1'b1;
                  expect_q  <= expect_i;
                  idx_q     <= 4'd0;
                  truth_q   <= 16'd0;
                  err_cnt_q <= 5'd0;
                  pass_q    <= 1'b0;
               end
            end
            S_SWEEP: begin
               if (abort_i) begin
                  // Abort wins over the final capture and discards partial results.
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  idx_q     <= 4'd0;
                  truth_q   <= 16'd0;
                  err_cnt_q <= 5'd0;
               end else begin
                  truth_q   <= truth_d;
                  err_cnt_q <= err_cnt_q + {4'd0, mism};
                  // Wraps to 0 after vector 15, which leaves the stimulus at 0.
                  idx_q     <= idx_q + 4'd1;
                  if (idx_q == 4'd15) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (truth_d == expect_q);
                  end
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef KMAP_SWEEP_FIRSTERR_EN
   logic [3:0] ferr_idx_q;
   logic       ferr_vld_q;

   // Latch the index of the first mismatch in a sweep; later mismatches are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ferr_idx_q <= 4'd0;
         ferr_vld_q <= 1'b0;
      end else if ((state_q == S_IDLE && start_i) || (state_q == S_SWEEP && abort_i)) begin
         ferr_idx_q <= 4'd0;
         ferr_vld_q <= 1'b0;
      end else if (state_q == S_SWEEP && mism && !ferr_vld_q) begin
         ferr_idx_q <= idx_q;
         ferr_vld_q <= 1'b1;
      end
   end

   assign first_err_idx_o = ferr_idx_q;
   assign first_err_vld_o = ferr_vld_q;
`else
   assign first_err_idx_o = 4'd0;
   assign first_err_vld_o = 1'b0;
`endif

   assign {kmap_a_o, kmap_b_o, kmap_c_o, kmap_d_o} = idx_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign truth_o   = truth_q;
   assign pass_o    = pass_q;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Bench for kmap_sweep_ctrl. It attaches a function under test with truth
// table 0xFA7A. A cycle-level model, built from sweep phase and table
// arithmetic, is checked against the DUT on every falling edge. Directed
// literal checks pin the model.
module tb_kmap_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [15:0] expect_i = 16'd0;
   logic        kmap_out_i;
   logic        kmap_a_o, kmap_b_o, kmap_c_o, kmap_d_o;
   logic        busy_o, done_o, pass_o, first_err_vld_o;
   logic [15:0] truth_o;
   logic [4:0]  err_cnt_o;
   logic [3:0]  first_err_idx_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   logic [15:0] fut = 16'hFA7A;

`ifdef KMAP_SWEEP_FIRSTERR_EN
   localparam bit FE = 1'b1;
`else
   localparam bit FE = 1'b0;
`endif

   always #5 clk = ~clk;

   assign kmap_out_i = fut[{kmap_a_o, kmap_b_o, kmap_c_o, kmap_d_o}];

   kmap_sweep_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .expect_i(expect_i), .kmap_out_i(kmap_out_i),
      .kmap_a_o(kmap_a_o), .kmap_b_o(kmap_b_o), .kmap_c_o(kmap_c_o), .kmap_d_o(kmap_d_o),
      .busy_o(busy_o), .done_o(done_o), .truth_o(truth_o), .pass_o(pass_o),
      .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o),
      .first_err_vld_o(first_err_vld_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] popc(input logic [15:0] v);
      logic [4:0] n = 5'd0;
      for (int i = 0; i < 16; i++) n += {4'd0, v[i]};
      return n;
   endfunction

   function automatic logic [3:0] lowbit(input logic [15:0] v);
      logic [3:0] r = 4'd0;
      for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
      return r;
   endfunction

   // Model: m_cnt = 0 idle, 1..16 sweep cycle (vector m_cnt-1), 17 done cycle.
   int          m_cnt;
   logic [15:0] m_exp, m_truth;
   logic [4:0]  m_err;
   logic [3:0]  m_fidx;
   logic        m_fvld, m_pass;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0; m_exp <= '0; m_truth <= '0; m_err <= '0;
         m_fidx <= '0; m_fvld <= 1'b0; m_pass <= 1'b0;
      end else if (m_cnt == 0) begin
         if (start_i) begin
            m_cnt <= 1; m_exp <= expect_i; m_truth <= '0; m_err <= '0;
            m_fidx <= '0; m_fvld <= 1'b0; m_pass <= 1'b0;
         end
      end else if (m_cnt <= 16) begin
         if (abort_i) begin
            m_cnt <= 0; m_truth <= '0; m_err <= '0; m_fidx <= '0; m_fvld <= 1'b0;
         end else if (m_cnt == 16) begin
            m_cnt   <= 17;
            m_truth <= fut;
            m_err   <= popc(fut ^ m_exp);
            m_pass  <= (fut == m_exp);
            if (FE) begin
               m_fidx <= lowbit(fut ^ m_exp);
               m_fvld <= (fut != m_exp);
            end
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end else begin
         m_cnt <= 0;
      end
   end

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy_o), 32'(m_cnt >= 1 && m_cnt <= 16));
         chk("done", 32'(done_o), 32'(m_cnt == 17));
         chk("kmap", 32'({kmap_a_o, kmap_b_o, kmap_c_o, kmap_d_o}),
             (m_cnt >= 1 && m_cnt <= 16) ? 32'(m_cnt - 1) : 32'd0);
         chk("pass", 32'(pass_o), 32'(m_pass));
         if (m_cnt == 0 || m_cnt == 17) begin
            chk("truth", 32'(truth_o), 32'(m_truth));
            chk("err_cnt", 32'(err_cnt_o), 32'(m_err));
            chk("first_err_idx", 32'(first_err_idx_o), 32'(m_fidx));
            chk("first_err_vld", 32'(first_err_vld_o), 32'(m_fvld));
         end
      end
   end

   // Start a sweep and return the number of falling edges until done (0 on timeout).
   task automatic sweep(input logic [15:0] e, input bit hold, output int lat);
      @(negedge clk); #1;
      expect_i = e; start_i = 1'b1;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done_o) begin lat = n; break; end
         #1; if (!hold) start_i = 1'b0;
      end
      if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done_o) n++;
      end
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_pass"}, 32'(pass_o), 32'd0);
      chk({tag, "_truth"}, 32'(truth_o), 32'd0);
      chk({tag, "_err"}, 32'(err_cnt_o), 32'd0);
      chk({tag, "_kmap"}, 32'({kmap_a_o, kmap_b_o, kmap_c_o, kmap_d_o}), 32'd0);
      chk({tag, "_fidx"}, 32'(first_err_idx_o), 32'd0);
      chk({tag, "_fvld"}, 32'(first_err_vld_o), 32'd0);
   endtask

   initial begin
      int lat, nd;
      #2 all_zero("rst");
      @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
      chk_en = 1'b1;

      // Golden sweep.
      sweep(16'hFA7A, 1'b0, lat);
      chk("gold_lat", 32'(lat), 32'd17);
      chk("gold_truth", 32'(truth_o), 32'hFA7A);
      chk("gold_pass", 32'(pass_o), 32'd1);
      chk("gold_err", 32'(err_cnt_o), 32'd0);
      chk("gold_fvld", 32'(first_err_vld_o), 32'd0);
      // An abort in DONE is ignored, and results stay held in IDLE.
      #1 abort_i = 1'b1;
      @(negedge clk); #1 abort_i = 1'b0;
      chk("held_pass", 32'(pass_o), 32'd1);
      chk("held_truth", 32'(truth_o), 32'hFA7A);

      // Single mismatch.
      sweep(16'hFA7B, 1'b0, lat);
      chk("one_lat", 32'(lat), 32'd17);
      chk("one_pass", 32'(pass_o), 32'd0);
      chk("one_err", 32'(err_cnt_o), 32'd1);
      chk("one_fidx", 32'(first_err_idx_o), 32'd0);
      chk("one_fvld", 32'(first_err_vld_o), FE ? 32'd1 : 32'd0);

      // Many mismatches.
      sweep(16'h0000, 1'b0, lat);
      chk("many_err", 32'(err_cnt_o), 32'd11);
      chk("many_pass", 32'(pass_o), 32'd0);
      chk("many_fidx", 32'(first_err_idx_o), FE ? 32'd1 : 32'd0);

      // Abort at idx 7.
      @(negedge clk); #1 expect_i = 16'hFA7A; start_i = 1'b1;
      @(negedge clk); #1 start_i = 1'b0;
      repeat (7) @(negedge clk);
      chk("abort_at7", 32'({kmap_a_o, kmap_b_o, kmap_c_o, kmap_d_o}), 32'd7);
      #1 abort_i = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_truth", 32'(truth_o), 32'd0);
      chk("abort_err", 32'(err_cnt_o), 32'd0);
      #1 abort_i = 1'b0;
      count_done(20, nd);
      chk("abort_nodone", 32'(nd), 32'd0);
      sweep(16'hFA7A, 1'b0, lat);
      chk("post_abort_pass", 32'(pass_o), 32'd1);

      // Reset at idx 10.
      @(negedge clk); #1 expect_i = 16'hFA7A; start_i = 1'b1;
      @(negedge clk); #1 start_i = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_at10", 32'({kmap_a_o, kmap_b_o, kmap_c_o, kmap_d_o}), 32'd10);
      #1 rst_n = 1'b0;
      #1 all_zero("async_rst");
      @(negedge clk); #1 rst_n = 1'b1;
      count_done(20, nd);
      chk("rst_nodone", 32'(nd), 32'd0);

      // The first start after reset release is accepted on the first edge.
      @(negedge clk); #1 rst_n = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1; expect_i = 16'hFA7A; start_i = 1'b1;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done_o) begin lat = n; break; end
         #1 start_i = 1'b0;
      end
      chk("rst_release_lat", 32'(lat), 32'd17);

      // Start held high through the sweep: one done, then IDLE, then a new sweep.
      sweep(16'hFA7A, 1'b1, lat);
      chk("hold_lat", 32'(lat), 32'd17);
      @(negedge clk);
      chk("hold_idle", 32'(busy_o), 32'd0);
      @(negedge clk);
      chk("hold_restart", 32'(busy_o), 32'd1);
      #1 start_i = 1'b0;
      count_done(30, nd);
      chk("hold_one_done", 32'(nd), 32'd1);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kmap_sweep_ctrl.md
KMAP_SWEEP_CTRL -- requirements
Module: kmap_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 abort  input  1  terminates an active sweep.
REQ-006 expect  input  16  golden truth table; bit i is the expected output for vector i = {A,B,C,D}, A = MSB.
REQ-007 kmap_a, kmap_b, kmap_c, kmap_d  output  1 each  stimulus to the external 4-input combinational function under test.
REQ-008 kmap_out  input  1  response of the function under test.
REQ-009 busy  output  1  high in SWEEP.
REQ-010 done  output  1  one-cycle pulse when results become valid.
REQ-011 truth  output  16  captured truth table.
REQ-012 pass  output  1  truth == expect_q.
REQ-013 err_cnt  output  5  number of mismatching bits, 0..16.
REQ-014 first_err_idx  output  4  lowest mismatching index (see Configuration).
REQ-015 first_err_vld  output  1  at least one mismatch exists (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, SWEEP and DONE.
REQ-017 Transitions SHALL be:
  - IDLE -> SWEEP on start=1; expect is registered into expect_q, idx is cleared to 0, and truth, err_cnt and first_err are cleared.
  - SWEEP -> DONE after the capture of idx 15.
  - DONE -> IDLE unconditionally after 1 cycle.
REQ-018 In SWEEP, {kmap_a,kmap_b,kmap_c,kmap_d} SHALL equal idx, driven from registers.
REQ-019 kmap_out SHALL be captured into truth[idx] at the rising edge that ends the cycle in which idx is driven; idx then increments by 1.
REQ-020 Throughput SHALL be 1 vector per cycle: the start edge plus 16 SWEEP cycles, with done=1 in the 17th cycle after start is sampled.
REQ-021 err_cnt SHALL increment on each captured bit that differs from expect_q[idx]; it saturates at 16 by construction and needs no wrap.
REQ-022 pass, err_cnt, truth and first_err_* SHALL be valid from the done cycle and held until the next accepted start or reset.
REQ-023 The kmap_* outputs SHALL be 0 in IDLE and DONE.
REQ-024 start SHALL be ignored in SWEEP and DONE; no queuing.
REQ-025 abort=1 in SWEEP SHALL return the FSM to IDLE at the next edge, with no done pulse, and truth, err_cnt and first_err_* cleared.
REQ-026 abort SHALL be ignored in IDLE and DONE.
REQ-027 If abort and the idx-15 capture occur in the same cycle, abort SHALL win.
REQ-028 pass SHALL be 0 whenever no completed sweep result is held.

Reset
REQ-029 On rst_n=0 the block SHALL immediately enter IDLE with the following values, independent of clk:
  - idx = 0, expect_q = 0, truth = 0, err_cnt = 0
  - busy = 0, done = 0, pass = 0
  - kmap_* = 0, first_err_idx = 0, first_err_vld = 0
REQ-030 Reset asserted mid-SWEEP SHALL discard the sweep; no done is issued after release.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-032 Macro KMAP_SWEEP_FIRSTERR_EN SHALL control first-error logging.
  - Defined: on the first mismatch in a sweep, first_err_idx is loaded with idx and first_err_vld is set; later mismatches do not update them.
  - Undefined: first_err_idx and first_err_vld are tied to 0 and no logging registers are present.
  - Port list, pass and err_cnt SHALL be identical in both builds.

Verification
REQ-033 Golden sweep: the real 4-input function under test (truth table 0xFA7A) is attached, expect=0xFA7A, start pulsed.
  - Required response: busy for 16 cycles, kmap_* walking 0..15, then done, truth=0xFA7A, pass=1, err_cnt=0, first_err_vld=0.
REQ-034 Single mismatch: expect=0xFA7B.
  - Required response: pass=0, err_cnt=1.
  - With the macro: first_err_idx=0, first_err_vld=1.
  - Without the macro: first_err_idx=0, first_err_vld=0.
REQ-035 Many mismatches: expect=0x0000.
  - Required response: err_cnt=11, pass=0.
  - With the macro: first_err_idx=1.
REQ-036 Abort: abort pulsed at idx=7.
  - Required response: IDLE next cycle, no done, truth=0, err_cnt=0.
  - A following start with expect=0xFA7A yields pass=1.
REQ-037 Reset and start filtering:
  - rst_n low at idx=10: all outputs go to 0 asynchronously and no done follows.
  - start held high through SWEEP: exactly one done, then a new sweep starts from IDLE.
